// File: rtl/ntt_pkg.sv
// Shared types, constants and address helpers for the NTT data-bank control path.
package ntt_pkg;

    localparam int NTT_ADDR_WIDTH = 6;
    localparam int NTT_DEPTH      = 64;
    localparam int NTT_STAGES     = 10;
    localparam int BFU_PIPE_LAT   = 4;
    localparam int ROT_MAX_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bank_ctrl_state_t;

    // Rotate the low w bits of addr left by sh (sh < w); bits above w read as zero.
    function automatic logic [ROT_MAX_W-1:0] rotl_addr(
        input logic [ROT_MAX_W-1:0] addr,
        input int                   sh,
        input int                   w = NTT_ADDR_WIDTH
    );
        logic [ROT_MAX_W-1:0] res;
        logic [3:0]           src;
        logic [3:0]           dst;
        res = '0;
        for (int i = 0; i < ROT_MAX_W; i++) begin
            src = 4'(i);
            dst = 4'((i + sh) % w);
            if (i < w) res[dst] = addr[src];
        end
        return res;
    endfunction

endpackage

// File: rtl/ntt_bank_ctrl_addr_delay_line.sv
// Fixed-depth shift register with synchronous active-low clear; carries {enable, address}.
module addr_delay_line #(
    parameter int W     = 7,
    parameter int DEPTH = 5
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            for (int i = 0; i < DEPTH; i++) r_sr[i] <= '0;
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/ntt_bank_ctrl.sv
// NTT stage sequencer: rotated read addresses per stage, writes replay reads WR_LAT cycles later.
//   state    | meaning
//   ST_IDLE  | waiting for i_start
//   ST_RUN   | one read per cycle, DEPTH reads per stage
//   ST_DRAIN | reads stopped, waiting for the stage's writes to land
//   ST_DONE  | one-cycle completion pulse
module ntt_bank_ctrl
    import ntt_pkg::*;
#(
    parameter int ADDR_WIDTH = NTT_ADDR_WIDTH,
    parameter int DEPTH      = NTT_DEPTH,
    parameter int STAGES     = NTT_STAGES,
    parameter int PIPE_LAT   = BFU_PIPE_LAT
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    output logic [ADDR_WIDTH-1:0]     o_ra,
    output logic                      o_ren,
    output logic [ADDR_WIDTH-1:0]     o_wa,
    output logic                      o_wen,
    output logic                      o_bank_en,
    output logic [$clog2(STAGES)-1:0] o_stage,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int WR_LAT = PIPE_LAT + 1;
    localparam int SW     = $clog2(STAGES);
    localparam int DW     = $clog2(WR_LAT) + 1;

    bank_ctrl_state_t      r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_ra;
    logic                  r_last;
    logic                  r_ren;
    logic                  r_busy;
    logic                  r_done;
    logic [SW-1:0]         r_stage;
    logic [DW-1:0]         r_drain;

    logic [ROT_MAX_W-1:0]  w_rot;
    logic [ADDR_WIDTH-1:0] w_ra_next;
    logic [ADDR_WIDTH:0]   w_dly;
    logic                  w_wen;
    logic [ADDR_WIDTH-1:0] w_wa;

    assign w_rot     = rotl_addr(ROT_MAX_W'(r_cnt), int'(r_stage) % ADDR_WIDTH, ADDR_WIDTH);
    assign w_ra_next = w_rot[ADDR_WIDTH-1:0];

    // r_cnt holds the next index to issue; index 0 of every stage is issued on entry to RUN.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ra    <= '0;
            r_last  <= 1'b0;
            r_ren   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_stage <= '0;
            r_drain <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_stage <= '0;
                        r_cnt   <= ADDR_WIDTH'(1);
                        r_last  <= 1'b0;
                        r_ren   <= 1'b1;
                        r_ra    <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (r_last) begin
                        r_ren   <= 1'b0;
                        r_drain <= DW'(WR_LAT - 1);
                        r_state <= ST_DRAIN;
                    end else begin
                        r_ra   <= w_ra_next;
                        r_cnt  <= r_cnt + 1'b1;
                        r_last <= (r_cnt == ADDR_WIDTH'(DEPTH - 1));
                    end
                end
                ST_DRAIN: begin
                    if (r_drain != '0) begin
                        r_drain <= r_drain - 1'b1;
                    end else if (r_stage == SW'(STAGES - 1)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_stage <= r_stage + 1'b1;
                        r_cnt   <= ADDR_WIDTH'(1);
                        r_last  <= 1'b0;
                        r_ren   <= 1'b1;
                        r_ra    <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    addr_delay_line #(
        .W     (ADDR_WIDTH + 1),
        .DEPTH (WR_LAT)
    ) u_wr_dly (
        .i_clk   (i_clk),
        .i_clr_n (i_rst_n),
        .i_d     ({r_ren, r_ra}),
        .o_q     (w_dly)
    );

    assign w_wen = w_dly[ADDR_WIDTH];
    assign w_wa  = w_dly[ADDR_WIDTH-1:0];

    assign o_ra      = r_ra;
    assign o_ren     = r_ren;
    assign o_wa      = w_wa;
    assign o_wen     = w_wen;
    assign o_bank_en = r_ren | w_wen;
    assign o_stage   = r_stage;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule
